// File: rtl/cpu_run_controller_if.sv
// Run-control bundle between the board/CPU side (master) and the run-control sequencer (slave).
// Pure wiring: no storage and no added latency.
// No backpressure: every signal is a level that is sampled each cycle.
// Optional feature macro: RUNCTL_BREAKPOINT_EN (adds bp_addr / bp_valid).
interface cpu_run_controller_if #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 32
);
    logic             cont;
    logic             step;
    logic             halt;
    logic [PC_W-1:0]  pc;
`ifdef RUNCTL_BREAKPOINT_EN
    logic [PC_W-1:0]  bp_addr;
    logic             bp_valid;
`endif
    logic             cpu_en;
    logic [1:0]       run_state;
    logic             halted;
    logic [CNT_W-1:0] instr_count;

`ifdef RUNCTL_BREAKPOINT_EN
    modport master (
        output cont, step, halt, pc, bp_addr, bp_valid,
        input  cpu_en, run_state, halted, instr_count
    );
    modport slave (
        input  cont, step, halt, pc, bp_addr, bp_valid,
        output cpu_en, run_state, halted, instr_count
    );
`else
    modport master (
        output cont, step, halt, pc,
        input  cpu_en, run_state, halted, instr_count
    );
    modport slave (
        input  cont, step, halt, pc,
        output cpu_en, run_state, halted, instr_count
    );
`endif
endinterface

// File: rtl/cpu_run_controller.sv
// Run-control sequencer: gates CPU commits, stops on HALT/breakpoint, resumes/steps on button edges.
// cpu_en is combinational in the current cycle; state/halted/instr_count update one clock later.
// No backpressure: button edges arriving in RUN or STEP are dropped, never queued.
// Optional feature macro: RUNCTL_BREAKPOINT_EN (PC breakpoint comparator and BREAK state).
module cpu_run_controller #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    cpu_run_controller_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_HALTED = 2'b01,
        ST_STEP   = 2'b10,
        ST_BREAK  = 2'b11
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             resume_first_q;
    logic             resume_first_d;
    logic             cont_q;
    logic             step_q;
    logic             cont_pulse;
    logic             step_pulse;
    logic             bp_hit;
    logic             cpu_en;
    logic [CNT_W-1:0] count_q;

    assign cont_pulse = bus.cont & ~cont_q;
    assign step_pulse = bus.step & ~step_q;

`ifdef RUNCTL_BREAKPOINT_EN
    assign bp_hit = bus.bp_valid & (bus.pc == bus.bp_addr);
`else
    // Without the comparator the PC only matters to the datapath, not to run control.
    logic unused_pc;
    assign unused_pc = ^bus.pc;
    assign bp_hit    = 1'b0;
`endif

    // Button history; reset loads 1 so a button held through reset does not fire on release.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cont_q <= 1'b1;
            step_q <= 1'b1;
        end else begin
            cont_q <= bus.cont;
            step_q <= bus.step;
        end
    end

    // State register plus the one-cycle step-over flag used right after a resume.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= ST_RUN;
            resume_first_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            resume_first_q <= resume_first_d;
        end
    end

    // Next-state: HALT beats breakpoint, cont beats step, the step-over cycle ignores both stops.
    always_comb begin
        state_d        = state_q;
        resume_first_d = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (!resume_first_q) begin
                    if (bus.halt)
                        state_d = ST_HALTED;
                    else if (bp_hit)
                        state_d = ST_BREAK;
                end
            end
            ST_HALTED, ST_BREAK: begin
                if (cont_pulse) begin
                    state_d        = ST_RUN;
                    resume_first_d = 1'b1;
                end else if (step_pulse) begin
                    state_d = ST_STEP;
                end
            end
            ST_STEP:  state_d = ST_HALTED;
            default:  state_d = ST_RUN;
        endcase
    end

    // Outputs: commit enable is held off in reset cycles so an aborted step never commits.
    always_comb begin
        cpu_en = 1'b0;
        if (reset) begin
            case (state_q)
                ST_RUN:  cpu_en = resume_first_q | ~(bus.halt | bp_hit);
                ST_STEP: cpu_en = 1'b1;
                default: cpu_en = 1'b0;
            endcase
        end
        bus.cpu_en    = cpu_en;
        bus.run_state = state_q;
        bus.halted    = (state_q == ST_HALTED) || (state_q == ST_BREAK);
    end

    // Committed-instruction counter, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (!reset)
            count_q <= '0;
        else if (cpu_en && (count_q != {CNT_W{1'b1}}))
            count_q <= count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    assign bus.instr_count = count_q;
endmodule

// File: tb/tb_cpu_run_controller.sv
module tb_cpu_run_controller;
    logic clk;
    logic rst_n;
    int   compared;
    int   failed;

    cpu_run_controller_if #(.PC_W(32), .CNT_W(32)) bus  ();
    cpu_run_controller_if #(.PC_W(32), .CNT_W(4))  bus4 ();

    cpu_run_controller #(.PC_W(32), .CNT_W(32)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    // Narrow-counter copy driven by identical inputs, used for the saturation check.
    cpu_run_controller #(.PC_W(32), .CNT_W(4)) dut4 (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus4)
    );

    assign bus4.cont = bus.cont;
    assign bus4.step = bus.step;
    assign bus4.halt = bus.halt;
    assign bus4.pc   = bus.pc;
`ifdef RUNCTL_BREAKPOINT_EN
    assign bus4.bp_addr  = bus.bp_addr;
    assign bus4.bp_valid = bus.bp_valid;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        cont;
        logic        step;
        logic        halt;
        logic [31:0] pc;
        logic        en;
        logic [1:0]  st;
        logic        hl;
        int          cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic r, input logic c, input logic s, input logic h,
                               input logic [31:0] p, input logic en, input logic [1:0] st,
                               input logic hl, input int cnt);
        vec_t x;
        x.rst = r; x.cont = c; x.step = s; x.halt = h; x.pc = p;
        x.en = en; x.st = st; x.hl = hl; x.cnt = cnt;
        return x;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    // Drive one cycle of inputs just after the edge, check mid-cycle, then advance to the next edge.
    task automatic apply(input vec_t x, input int idx);
        int c4;
        rst_n    = x.rst;
        bus.cont = x.cont;
        bus.step = x.step;
        bus.halt = x.halt;
        bus.pc   = x.pc;
        @(negedge clk);
        c4 = (x.cnt > 15) ? 15 : x.cnt;
        chk("cpu_en",      idx, {31'b0, bus.cpu_en},     {31'b0, x.en});
        chk("run_state",   idx, {30'b0, bus.run_state},  {30'b0, x.st});
        chk("halted",      idx, {31'b0, bus.halted},     {31'b0, x.hl});
        chk("instr_count", idx, bus.instr_count,         x.cnt);
        chk("count_sat4",  idx, {28'b0, bus4.instr_count}, c4);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        compared = 0;
        failed   = 0;
        rst_n    = 1'b0;
        bus.cont = 1'b1;
        bus.step = 1'b0;
        bus.halt = 1'b0;
        bus.pc   = 32'h0;
`ifdef RUNCTL_BREAKPOINT_EN
        bus.bp_valid = 1'b0;
        bus.bp_addr  = 32'h10;
`endif
        //            rst c s h  pc   en st hl cnt
        // reset held 3 cycles with cont high
        tbl.push_back(v(0, 1, 0, 0, 0,  0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0,  0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0,  0, 0, 0, 0));
        // release: run, no spurious resume from held cont
        tbl.push_back(v(1, 1, 0, 0, 0,  1, 0, 0, 0));
        for (int k = 1; k <= 4; k++)
            tbl.push_back(v(1, 0, 0, 0, 0,  1, 0, 0, k));
        // HALT at count 5
        tbl.push_back(v(1, 0, 0, 1, 0,  0, 0, 0, 5));
        tbl.push_back(v(1, 0, 0, 1, 0,  0, 1, 1, 5));
        tbl.push_back(v(1, 1, 0, 1, 0,  0, 1, 1, 5));
        // step-over of HALT, then run continues
        tbl.push_back(v(1, 1, 0, 1, 0,  1, 0, 0, 5));
        tbl.push_back(v(1, 0, 0, 0, 0,  1, 0, 0, 6));
        tbl.push_back(v(1, 0, 0, 0, 0,  1, 0, 0, 7));
        tbl.push_back(v(1, 0, 0, 1, 0,  0, 0, 0, 8));
        tbl.push_back(v(1, 0, 0, 1, 0,  0, 1, 1, 8));
        // three single steps, 4 cycles apart, HALT still decoding
        tbl.push_back(v(1, 0, 1, 1, 0,  0, 1, 1, 8));
        tbl.push_back(v(1, 0, 1, 1, 0,  1, 2, 0, 8));
        tbl.push_back(v(1, 0, 0, 1, 0,  0, 1, 1, 9));
        tbl.push_back(v(1, 0, 0, 1, 0,  0, 1, 1, 9));
        tbl.push_back(v(1, 0, 1, 1, 0,  0, 1, 1, 9));
        tbl.push_back(v(1, 0, 1, 1, 0,  1, 2, 0, 9));
        tbl.push_back(v(1, 0, 0, 1, 0,  0, 1, 1, 10));
        tbl.push_back(v(1, 0, 0, 1, 0,  0, 1, 1, 10));
        tbl.push_back(v(1, 0, 1, 1, 0,  0, 1, 1, 10));
        tbl.push_back(v(1, 0, 0, 1, 0,  1, 2, 0, 10));
        tbl.push_back(v(1, 0, 0, 1, 0,  0, 1, 1, 11));
        tbl.push_back(v(1, 0, 0, 1, 0,  0, 1, 1, 11));
        // cont and step together: cont wins
        tbl.push_back(v(1, 1, 1, 1, 0,  0, 1, 1, 11));
        tbl.push_back(v(1, 1, 1, 1, 0,  1, 0, 0, 11));
        tbl.push_back(v(1, 0, 0, 0, 0,  1, 0, 0, 12));
        // button edges in RUN are ignored
        tbl.push_back(v(1, 0, 1, 0, 0,  1, 0, 0, 13));
        tbl.push_back(v(1, 0, 1, 0, 0,  1, 0, 0, 14));
        tbl.push_back(v(1, 1, 0, 0, 0,  1, 0, 0, 15));
        tbl.push_back(v(1, 0, 0, 0, 0,  1, 0, 0, 16));
        tbl.push_back(v(1, 0, 0, 1, 0,  0, 0, 0, 17));
        tbl.push_back(v(1, 0, 0, 1, 0,  0, 1, 1, 17));
        tbl.push_back(v(1, 0, 0, 1, 0,  0, 1, 1, 17));
        // reset in the middle of a step: no commit, counter cleared
        tbl.push_back(v(1, 0, 1, 1, 0,  0, 1, 1, 17));
        tbl.push_back(v(0, 0, 1, 1, 0,  0, 2, 0, 17));
        tbl.push_back(v(0, 0, 1, 1, 0,  0, 0, 0, 0));
        // HALT at the reset PC stops at once; step held through reset does not fire
        tbl.push_back(v(1, 0, 1, 1, 0,  0, 0, 0, 0));
        tbl.push_back(v(1, 0, 1, 1, 0,  0, 1, 1, 0));
        tbl.push_back(v(1, 0, 1, 1, 0,  0, 1, 1, 0));
        tbl.push_back(v(1, 0, 0, 0, 0,  0, 1, 1, 0));

        foreach (tbl[i]) apply(tbl[i], i);
        base = tbl.size();

        // Long run: the 4-bit counter must stick at 15 while the wide one keeps counting.
        apply(v(1, 1, 0, 0, 0,  0, 1, 1, 0), base);
        for (int i = 0; i < 20; i++)
            apply(v(1, 0, 0, 0, 0,  1, 0, 0, i), base + 1 + i);
        apply(v(1, 0, 0, 0, 0,  1, 0, 0, 20), base + 21);

`ifdef RUNCTL_BREAKPOINT_EN
        // Breakpoint at 0x10: stop without commit, cont steps over it once.
        bus.bp_valid = 1'b1;
        bus.bp_addr  = 32'h10;
        apply(v(1, 0, 0, 1, 32'h0C,  0, 0, 0, 21), base + 22);
        apply(v(1, 0, 0, 1, 32'h0C,  0, 1, 1, 21), base + 23);
        apply(v(1, 1, 0, 0, 32'h0C,  0, 1, 1, 21), base + 24);
        apply(v(1, 1, 0, 0, 32'h0C,  1, 0, 0, 21), base + 25);
        apply(v(1, 0, 0, 0, 32'h10,  0, 0, 0, 22), base + 26);
        apply(v(1, 0, 0, 0, 32'h10,  0, 3, 1, 22), base + 27);
        apply(v(1, 1, 0, 0, 32'h10,  0, 3, 1, 22), base + 28);
        apply(v(1, 1, 0, 0, 32'h10,  1, 0, 0, 22), base + 29);
        apply(v(1, 0, 0, 0, 32'h14,  1, 0, 0, 23), base + 30);
        apply(v(1, 0, 0, 0, 32'h18,  1, 0, 0, 24), base + 31);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end
endmodule
